// File: rtl/tdm_frame_bridge_pkg.sv
// rtl/tdm_frame_bridge_pkg.sv - shared sizes, sample types and RX conversion for the TDM frame bridge
package nanomixer_tdm_pkg;

  localparam int NUM_CHANNELS   = 8;
  localparam int DATA_WIDTH     = 36;
  localparam int AUDIO_WIDTH    = 24;
  localparam int SLOT_BITS      = 32;
  localparam int HEADROOM_SHIFT = 10;
  localparam int SLOT_W         = $clog2(NUM_CHANNELS);
  localparam int BIT_W          = $clog2(SLOT_BITS);

  typedef logic [DATA_WIDTH-1:0]  dsp_sample_t;
  typedef logic [AUDIO_WIDTH-1:0] audio_sample_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

  // Serial audio word into DSP headroom format: sign-extend, then left-justify by the headroom shift.
  function automatic dsp_sample_t rx_convert(audio_sample_t s);
    dsp_sample_t ext;
    ext = {{(DATA_WIDTH-AUDIO_WIDTH){s[AUDIO_WIDTH-1]}}, s};
    return ext << HEADROOM_SHIFT;
  endfunction

endpackage

// File: rtl/tdm_frame_bridge_if.sv
// rtl/tdm_frame_bridge_if.sv - serial TDM link between the codec front end and the frame bridge
interface tdm_frame_bridge_if;

  logic bit_en;
  logic fsync;
  logic sdin;
  logic sdout;

  modport master (
    output bit_en,
    output fsync,
    output sdin,
    input  sdout
  );

  modport slave (
    input  bit_en,
    input  fsync,
    input  sdin,
    output sdout
  );

endinterface

// File: rtl/tdm_frame_bridge_tx_convert.sv
// rtl/tdm_frame_bridge_tx_convert.sv - DSP word to TX slot word
// TDM_TX_SAT_EN defined: saturate to the signed audio range; undefined: take the window bits (wraps).
module tdm_tx_convert
  import nanomixer_tdm_pkg::*;
(
  input  dsp_sample_t   sample_i,
  output audio_sample_t audio_o
);

`ifdef TDM_TX_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(2 ** (AUDIO_WIDTH - 1) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_WIDTH-1:0] shifted;

  assign shifted = $signed(sample_i) >>> HEADROOM_SHIFT;

  always_comb begin
    audio_o = shifted[AUDIO_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      audio_o = SAT_MAX[AUDIO_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      audio_o = SAT_MIN[AUDIO_WIDTH-1:0];
    end
  end
`else
  logic unused_bits;

  assign audio_o     = sample_i[HEADROOM_SHIFT+AUDIO_WIDTH-1:HEADROOM_SHIFT];
  assign unused_bits = ^{sample_i[DATA_WIDTH-1:HEADROOM_SHIFT+AUDIO_WIDTH],
                         sample_i[HEADROOM_SHIFT-1:0]};
`endif

endmodule

// File: rtl/tdm_frame_bridge.sv
// rtl/tdm_frame_bridge.sv - 8-slot TDM <-> DSPCore frame bridge (RX assemble + start, TX capture + serialize)
// TX saturation is selected by TDM_TX_SAT_EN inside tdm_tx_convert.
module tdm_frame_bridge
  import nanomixer_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  tdm_frame_bridge_if.slave tdm,
  output logic              start,
  output dsp_sample_t       inputs  [NUM_CHANNELS],
  input  dsp_sample_t       outputs [NUM_CHANNELS],
  output logic              locked,
  output logic              frame_err
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHANNELS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]  PAD_BIT   = BIT_W'(AUDIO_WIDTH);

  frame_state_t         state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [SLOT_BITS-2:0] shreg_q, shreg_d;
  audio_sample_t        rx_buf_q [NUM_CHANNELS];
  audio_sample_t        rx_buf_d [NUM_CHANNELS];
  dsp_sample_t          inputs_q [NUM_CHANNELS];
  dsp_sample_t          inputs_d [NUM_CHANNELS];
  audio_sample_t        tx_buf_q [NUM_CHANNELS];
  audio_sample_t        tx_buf_d [NUM_CHANNELS];
  audio_sample_t        tx_conv  [NUM_CHANNELS];
  logic                 start_q, start_d;
  logic                 sdout_q, sdout_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 at_boundary;
  logic [SLOT_W-1:0]    cur_slot;
  logic [BIT_W-1:0]     cur_bit;
  audio_sample_t        rx_word;
  audio_sample_t        tx_word;
  audio_sample_t        tx_shift;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_tx_conv
    tdm_tx_convert u_tx_convert (
      .sample_i (outputs[k]),
      .audio_o  (tx_conv[k])
    );
  end

  // Shift register holds the first SLOT_BITS-1 bits of the slot; the audio word is complete before sdin's pad bit.
  assign rx_word     = shreg_q[SLOT_BITS-2 -: AUDIO_WIDTH];
  assign at_boundary = (slot_q == '0) && (bit_q == '0);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    rx_buf_d = rx_buf_q;
    inputs_d = inputs_q;
    tx_buf_d = tx_buf_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    sdout_d  = sdout_q;
    accept   = 1'b0;
    cur_slot = slot_q;
    cur_bit  = bit_q;
    tx_word  = '0;
    tx_shift = '0;

    if (start_q) begin
      tx_buf_d = tx_conv;
    end

    if (tdm.bit_en) begin
      case (state_q)
        HUNT: begin
          if (tdm.fsync) begin
            state_d  = RUN;
            accept   = 1'b1;
            cur_slot = '0;
            cur_bit  = '0;
          end
        end
        RUN: begin
          if (tdm.fsync) begin
            err_d    = !at_boundary;
            accept   = 1'b1;
            cur_slot = '0;
            cur_bit  = '0;
          end else if (at_boundary) begin
            state_d = HUNT;
            err_d   = 1'b1;
            sdout_d = 1'b0;
          end else begin
            accept = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (accept) begin
      shreg_d = {shreg_q[SLOT_BITS-3:0], tdm.sdin};
      // During the start cycle the capture has not landed yet, so transmit straight from the converters.
      tx_word  = start_q ? tx_conv[cur_slot] : tx_buf_q[cur_slot];
      tx_shift = tx_word << cur_bit;
      sdout_d  = (cur_bit < PAD_BIT) ? tx_shift[AUDIO_WIDTH-1] : 1'b0;
      slot_d   = cur_slot;
      bit_d    = cur_bit + 1'b1;
      if (cur_bit == LAST_BIT) begin
        rx_buf_d[cur_slot] = rx_word;
        bit_d              = '0;
        slot_d             = (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;
        if (cur_slot == LAST_SLOT) begin
          start_d = 1'b1;
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            inputs_d[k] = rx_convert((k == NUM_CHANNELS - 1) ? rx_word : rx_buf_q[k]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      slot_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      start_q <= 1'b0;
      sdout_q <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        rx_buf_q[k] <= '0;
        inputs_q[k] <= '0;
        tx_buf_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      start_q  <= start_d;
      sdout_q  <= sdout_d;
      err_q    <= err_d;
      rx_buf_q <= rx_buf_d;
      inputs_q <= inputs_d;
      tx_buf_q <= tx_buf_d;
    end
  end

  assign start     = start_q;
  assign frame_err = err_q;
  assign locked    = (state_q == RUN);
  assign inputs    = inputs_q;
  assign tdm.sdout = sdout_q;

endmodule

// File: tb/tb_tdm_frame_bridge.sv
// tb/tb_tdm_frame_bridge.sv - randomized directed-sequence bench with a frame-level reference model
module tb_tdm_frame_bridge;
  import nanomixer_tdm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, locked, frame_err;
  dsp_sample_t inputs [8];
  dsp_sample_t outs   [8];

  tdm_frame_bridge_if tdm_if ();

  tdm_frame_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .tdm       (tdm_if),
    .start     (start),
    .inputs    (inputs),
    .outputs   (outs),
    .locked    (locked),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  bit          m_locked;
  int          m_pos;
  logic        m_sdout, m_start, m_err;
  logic [23:0] m_tx [8];
  logic [35:0] m_in [8];
  logic        m_bits [256];
  logic        obs_bits [256];
  logic [23:0] smp [8];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] rx_model(input logic [23:0] w);
    longint v;
    v = longint'($signed(w)) * 1024;
    return v[35:0];
  endfunction

  function automatic logic [23:0] tx_model(input logic [35:0] x);
    longint y;
    y = longint'($signed(x)) >>> 10;
`ifdef TDM_TX_SAT_EN
    if (y > 64'sd8388607) y = 64'sd8388607;
    if (y < -64'sd8388608) y = -64'sd8388608;
`endif
    return y[23:0];
  endfunction

  function automatic logic [23:0] frame_word(input int k);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[23-i] = m_bits[k*32+i];
    return w;
  endfunction

  function automatic logic [31:0] obs_slot(input int k);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = obs_bits[k*32+i];
    return w;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_sdout  = 1'b0;
    m_start  = 1'b0;
    m_err    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_tx[k] = '0;
      m_in[k] = '0;
    end
  endtask

  task automatic check_inputs(input string why);
    for (int k = 0; k < 8; k++) chk($sformatf("%s inputs[%0d]", why, k), inputs[k], m_in[k]);
  endtask

  task automatic tick(input logic be, input logic fs, input logic d);
    bit acc;
    int p;
    tdm_if.bit_en = be;
    tdm_if.fsync  = fs;
    tdm_if.sdin   = d;
    if (m_start) begin
      for (int k = 0; k < 8; k++) m_tx[k] = tx_model(outs[k]);
    end
    m_start = 1'b0;
    m_err   = 1'b0;
    acc     = 0;
    p       = 0;
    if (be) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1;
          m_pos    = 0;
          acc      = 1;
        end
      end else if (fs) begin
        if (m_pos != 0) m_err = 1'b1;
        m_pos = 0;
        acc   = 1;
      end else if (m_pos == 0) begin
        m_err    = 1'b1;
        m_locked = 0;
        m_sdout  = 1'b0;
      end else begin
        acc = 1;
      end
    end
    if (acc) begin
      p         = m_pos;
      m_bits[p] = d;
      m_sdout   = (p % 32 < 24) ? m_tx[p/32][23 - p%32] : 1'b0;
      if (p == 255) begin
        m_start = 1'b1;
        for (int k = 0; k < 8; k++) m_in[k] = rx_model(frame_word(k));
      end
      m_pos = (p + 1) % 256;
    end
    @(posedge clk);
    @(negedge clk);
    chk("start", start, m_start);
    chk("frame_err", frame_err, m_err);
    chk("locked", locked, m_locked);
    chk("sdout", tdm_if.sdout, m_sdout);
    if (acc) obs_bits[p] = tdm_if.sdout;
    if (m_start || m_err) check_inputs(m_start ? "frame" : "error");
  endtask

  task automatic send_frame(input bit with_fs, input int nbits, input logic [23:0] s [8]);
    for (int p = 0; p < nbits; p++) begin
      logic d;
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      d = (p % 32 < 24) ? s[p/32][23 - p%32] : 1'($urandom_range(0, 1));
      tick(1'b1, with_fs && (p == 0), d);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 8; k++) begin
      smp[k]  = 24'($urandom);
      outs[k] = ($urandom_range(0, 1) == 1) ? 36'({$urandom, $urandom}) : rx_model(24'($urandom));
    end
  endtask

  task automatic pulse_reset();
    reset         = 1'b0;
    tdm_if.bit_en = 1'b1;
    tdm_if.fsync  = 1'($urandom_range(0, 1));
    tdm_if.sdin   = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset start", start, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset locked", locked, 1'b0);
    chk("reset sdout", tdm_if.sdout, 1'b0);
    check_inputs("reset");
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    tdm_if.bit_en = 1'b0;
    tdm_if.fsync  = 1'b0;
    tdm_if.sdin   = 1'b0;
    for (int k = 0; k < 8; k++) outs[k] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    pulse_reset();

    rand_frame();
    smp[0]  = 24'h000001;
    smp[3]  = 24'h800000;
    smp[7]  = 24'h7FFFFF;
    outs[2] = 36'h000000C00;
    outs[5] = 36'h7FFFFFFFF;
    outs[6] = 36'h800000000;
    send_frame(1, 256, smp);
    chk("dir inputs[0]", inputs[0], 36'h000000400);
    chk("dir inputs[3]", inputs[3], 36'hE00000000);
    chk("dir inputs[7]", inputs[7], 36'h1FFFFFC00);
    chk("dir locked", locked, 1'b1);

    for (int k = 0; k < 8; k++) smp[k] = 24'($urandom);
    send_frame(1, 256, smp);
    chk("dir tx slot2", obs_slot(2), 32'h00000300);
`ifdef TDM_TX_SAT_EN
    chk("dir tx slot5", obs_slot(5), 32'h7FFFFF00);
    chk("dir tx slot6", obs_slot(6), 32'h80000000);
`else
    chk("dir tx slot5", obs_slot(5), 32'hFFFFFF00);
    chk("dir tx slot6", obs_slot(6), 32'h00000000);
`endif

    repeat (4) begin
      rand_frame();
      send_frame(1, 256, smp);
    end

    rand_frame();
    send_frame(1, 4*32 + 10, smp);
    rand_frame();
    send_frame(1, 256, smp);
    chk("early fsync relock", locked, 1'b1);
    rand_frame();
    send_frame(1, 256, smp);

    rand_frame();
    send_frame(0, 256, smp);
    chk("missing fsync locked", locked, 1'b0);
    chk("missing fsync sdout", tdm_if.sdout, 1'b0);
    rand_frame();
    send_frame(1, 256, smp);
    rand_frame();
    send_frame(1, 256, smp);

    rand_frame();
    send_frame(1, 5*32 + 7, smp);
    pulse_reset();
    rand_frame();
    send_frame(1, 256, smp);
    rand_frame();
    send_frame(1, 256, smp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
